// File: rtl/pb_tap_loader.sv
// JTAG TAP controller that loads instruction memory from a host, with IDCODE,
// auto-incrementing burst loads, write readback and DR shift-length checking.
module pb_tap_loader #(
    parameter int                IR_W      = 4,
    parameter int                ADDR_W    = 64,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(1),
    parameter logic [31:0]       IDCODE    = 32'h1000_0A6B
) (
    input  logic              tck_i,
    input  logic              trst_i,
    input  logic              tms_i,
    input  logic              tdi_i,
    output logic              tdo_o,
    output logic [ADDR_W-1:0] loadAddr_o,
    output logic [DATA_W-1:0] loadData_o,
    output logic              wEn_o,
    output logic              err_o,
    output logic [3:0]        tapState_o
);

    localparam int          PROG_W    = ADDR_W + DATA_W;
    localparam logic [15:0] PROG_LEN  = 16'(PROG_W);
    localparam logic [15:0] BURST_LEN = 16'(DATA_W);

    localparam logic [IR_W-1:0] IR_PROG   = IR_W'(1);
    localparam logic [IR_W-1:0] IR_SCAN   = IR_W'(2);
    localparam logic [IR_W-1:0] IR_IDCODE = IR_W'(4);
    localparam logic [IR_W-1:0] IR_BURST  = IR_W'(5);

    typedef enum logic [3:0] {
        TLR      = 4'd0,
        RTI      = 4'd1,
        SEL_DR   = 4'd2,
        CAP_DR   = 4'd3,
        SHIFT_DR = 4'd4,
        EX1_DR   = 4'd5,
        PAUSE_DR = 4'd6,
        EX2_DR   = 4'd7,
        UPD_DR   = 4'd8,
        SEL_IR   = 4'd9,
        CAP_IR   = 4'd10,
        SHIFT_IR = 4'd11,
        EX1_IR   = 4'd12,
        PAUSE_IR = 4'd13,
        EX2_IR   = 4'd14,
        UPD_IR   = 4'd15
    } tap_state_e;

    typedef enum logic [2:0] {
        INS_PROG,
        INS_SCAN,
        INS_BYPASS,
        INS_IDCODE,
        INS_BURST
    } ins_e;

    tap_state_e        state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
    logic [PROG_W-1:0] prog_sr_q, prog_sr_d;
    logic [DATA_W-1:0] burst_sr_q, burst_sr_d;
    logic [31:0]       id_sr_q, id_sr_d;
    logic              byp_q, byp_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wen_q, wen_d;
    ins_e              ins;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms_i ? TLR    : RTI;
            RTI:      state_d = tms_i ? SEL_DR : RTI;
            SEL_DR:   state_d = tms_i ? SEL_IR : CAP_DR;
            CAP_DR:   state_d = tms_i ? EX1_DR : SHIFT_DR;
            SHIFT_DR: state_d = tms_i ? EX1_DR : SHIFT_DR;
            EX1_DR:   state_d = tms_i ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_d = tms_i ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_d = tms_i ? UPD_DR : SHIFT_DR;
            UPD_DR:   state_d = tms_i ? SEL_DR : RTI;
            SEL_IR:   state_d = tms_i ? TLR    : CAP_IR;
            CAP_IR:   state_d = tms_i ? EX1_IR : SHIFT_IR;
            SHIFT_IR: state_d = tms_i ? EX1_IR : SHIFT_IR;
            EX1_IR:   state_d = tms_i ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_d = tms_i ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_d = tms_i ? UPD_IR : SHIFT_IR;
            UPD_IR:   state_d = tms_i ? SEL_DR : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Undefined codes, including all-ones, fall through to BYPASS.
    always_comb begin
        ins = INS_BYPASS;
        case (ir_q)
            IR_PROG:   ins = INS_PROG;
            IR_SCAN:   ins = INS_SCAN;
            IR_IDCODE: ins = INS_IDCODE;
            IR_BURST:  ins = INS_BURST;
            default:   ins = INS_BYPASS;
        endcase
    end

    always_comb begin
        ir_d       = ir_q;
        ir_sr_d    = ir_sr_q;
        prog_sr_d  = prog_sr_q;
        burst_sr_d = burst_sr_q;
        id_sr_d    = id_sr_q;
        byp_d      = byp_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wen_d      = 1'b0;

        case (state_q)
            CAP_IR:   ir_sr_d = IR_W'(1);
            SHIFT_IR: ir_sr_d = {tdi_i, ir_sr_q[IR_W-1:1]};
            UPD_IR:   ir_d    = ir_sr_q;
            CAP_DR: begin
                cnt_d = 16'd0;
                case (ins)
                    INS_PROG, INS_SCAN: prog_sr_d  = {data_q, addr_q};
                    INS_BURST:          burst_sr_d = data_q;
                    INS_IDCODE:         id_sr_d    = IDCODE;
                    default:            byp_d      = 1'b0;
                endcase
            end
            SHIFT_DR: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                case (ins)
                    INS_PROG, INS_SCAN: prog_sr_d  = {tdi_i, prog_sr_q[PROG_W-1:1]};
                    INS_BURST:          burst_sr_d = {tdi_i, burst_sr_q[DATA_W-1:1]};
                    INS_IDCODE:         id_sr_d    = {tdi_i, id_sr_q[31:1]};
                    default:            byp_d      = tdi_i;
                endcase
            end
            // A write only commits when exactly the DR length was shifted since capture.
            UPD_DR: begin
                if (ins == INS_PROG) begin
                    if (cnt_q == PROG_LEN) begin
                        addr_d = prog_sr_q[ADDR_W-1:0];
                        data_d = prog_sr_q[PROG_W-1:ADDR_W];
                        ptr_d  = prog_sr_q[ADDR_W-1:0] + ADDR_STEP;
                        wen_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ins == INS_BURST) begin
                    if (cnt_q == BURST_LEN) begin
                        addr_d = ptr_q;
                        data_d = burst_sr_q;
                        ptr_d  = ptr_q + ADDR_STEP;
                        wen_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (state_d == TLR) begin
            ir_d  = IR_IDCODE;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge tck_i) begin
        if (trst_i) begin
            state_q    <= TLR;
            ir_q       <= IR_IDCODE;
            ir_sr_q    <= '0;
            prog_sr_q  <= '0;
            burst_sr_q <= '0;
            id_sr_q    <= '0;
            byp_q      <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            ptr_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_sr_q    <= ir_sr_d;
            prog_sr_q  <= prog_sr_d;
            burst_sr_q <= burst_sr_d;
            id_sr_q    <= id_sr_d;
            byp_q      <= byp_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wen_q      <= wen_d;
        end
    end

    always_comb begin
        tdo_o = 1'b0;
        if (state_q == SHIFT_IR) begin
            tdo_o = ir_sr_q[0];
        end else if (state_q == SHIFT_DR) begin
            case (ins)
                INS_PROG, INS_SCAN: tdo_o = prog_sr_q[0];
                INS_BURST:          tdo_o = burst_sr_q[0];
                INS_IDCODE:         tdo_o = id_sr_q[0];
                default:            tdo_o = byp_q;
            endcase
        end
    end

    assign loadAddr_o = addr_q;
    assign loadData_o = data_q;
    assign wEn_o      = wen_q;
    assign err_o      = err_q;
    assign tapState_o = state_q;

endmodule

// File: tb/tb_pb_tap_loader.sv
// Randomized scoreboard bench for pb_tap_loader: the driver pushes expected writes
// and tdo streams from a transaction-level model; a negedge monitor pops and compares.
module tb_pb_tap_loader;

    localparam int IR_W = 4;
    localparam logic [3:0] ST_TLR      = 4'd0;
    localparam logic [3:0] ST_RTI      = 4'd1;
    localparam logic [3:0] ST_SHIFT_DR = 4'd4;

    logic        tck_i = 1'b0;
    logic        trst_i = 1'b0;
    logic        tms_i = 1'b1;
    logic        tdi_i = 1'b0;
    logic        tdo_o;
    logic [63:0] loadAddr_o;
    logic [31:0] loadData_o;
    logic        wEn_o;
    logic        err_o;
    logic [3:0]  tapState_o;

    pb_tap_loader dut (
        .tck_i      (tck_i),
        .trst_i     (trst_i),
        .tms_i      (tms_i),
        .tdi_i      (tdi_i),
        .tdo_o      (tdo_o),
        .loadAddr_o (loadAddr_o),
        .loadData_o (loadData_o),
        .wEn_o      (wEn_o),
        .err_o      (err_o),
        .tapState_o (tapState_o)
    );

    always #5 tck_i = ~tck_i;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int           len;
        logic [127:0] val;
    } tdo_t;

    wr_t  wr_q[$];
    tdo_t tdo_q[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_addr = '0;
    logic [63:0] m_data_w = '0;
    logic [31:0] m_data = '0;
    logic [63:0] m_ptr = '0;
    logic        m_err = 1'b0;

    logic         tdo_watch = 1'b0;
    logic [127:0] tdo_acc = '0;
    int           tdo_cnt = 0;
    logic         prev_wen = 1'b0;
    wr_t          mon_w;
    tdo_t         mon_t;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge tck_i);
        #1;
    endtask

    task automatic ir_scan(input logic [IR_W-1:0] v);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < IR_W; i++) applyStimulus(i == IR_W - 1, v[i]);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    // Starts and ends in RTI; optional pause after pause_at bits, optional reset on the update edge.
    task automatic dr_scan(input logic [127:0] bits, input int n, input int pause_at, input bit rst_upd);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            bit brk;
            brk = (i == n - 1) || (pause_at > 0 && i == pause_at - 1);
            applyStimulus(brk, bits[i]);
            if (pause_at > 0 && i == pause_at - 1 && i != n - 1) begin
                applyStimulus(1'b0, 1'b0);
                applyStimulus(1'b0, 1'b0);
                applyStimulus(1'b1, 1'b0);
                applyStimulus(1'b0, 1'b0);
            end
        end
        applyStimulus(1'b1, 1'b0);
        if (rst_upd) begin
            trst_i = 1'b1;
            applyStimulus(1'b0, 1'b0);
            trst_i = 1'b0;
        end
        applyStimulus(1'b0, 1'b0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_model(input string tag);
        checkOutput({tag, "_err"}, 128'(err_o), 128'(m_err));
        checkOutput({tag, "_addr"}, 128'(loadAddr_o), 128'(m_addr));
        checkOutput({tag, "_data"}, 128'(loadData_o), 128'(m_data));
    endtask

    task automatic do_program(input logic [63:0] a, input logic [31:0] d, input int pause_at);
        ir_scan(4'b0001);
        wr_q.push_back('{a, d});
        m_addr = a;
        m_data = d;
        m_ptr  = a + 64'd1;
        dr_scan({32'h0, d, a}, 96, pause_at, 1'b0);
    endtask

    task automatic do_burst(input logic [31:0] d);
        ir_scan(4'b0101);
        wr_q.push_back('{m_ptr, d});
        m_addr = m_ptr;
        m_data = d;
        m_ptr  = m_ptr + 64'd1;
        dr_scan({96'h0, d}, 32, 0, 1'b0);
    endtask

    task automatic do_bad(input bit burst, input int n);
        ir_scan(burst ? 4'b0101 : 4'b0001);
        m_err = 1'b1;
        dr_scan(rnd128(), n, 0, 1'b0);
    endtask

    task automatic do_expect_tdo(input logic [IR_W-1:0] code, input bit load_ir, input logic [127:0] bits,
                                 input int n, input logic [127:0] exp);
        if (load_ir) ir_scan(code);
        tdo_q.push_back('{n, exp});
        tdo_watch = 1'b1;
        dr_scan(bits, n, 0, 1'b0);
        tdo_watch = 1'b0;
    endtask

    function automatic logic [127:0] bypass_exp(input logic [127:0] bits, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 1; i < n; i++) r[i] = bits[i-1];
        return r;
    endfunction

    task automatic go_tlr_then_rti();
        repeat (5) applyStimulus(1'b1, 1'b0);
        m_err = 1'b0;
        checkOutput("tlr_state", 128'(tapState_o), 128'(ST_TLR));
        checkOutput("tlr_err", 128'(err_o), 128'(0));
        applyStimulus(1'b0, 1'b0);
    endtask

    always @(negedge tck_i) begin
        if (wEn_o === 1'b1) begin
            checkOutput("wen_single_cycle", 128'(prev_wen), 128'(0));
            if (wr_q.size() == 0) begin
                checkOutput("unexpected_write", 128'(1), 128'(0));
            end else begin
                mon_w = wr_q.pop_front();
                checkOutput("write_addr", 128'(loadAddr_o), 128'(mon_w.addr));
                checkOutput("write_data", 128'(loadData_o), 128'(mon_w.data));
            end
        end
        prev_wen = (wEn_o === 1'b1);
        if (tdo_watch && tapState_o == ST_SHIFT_DR) begin
            tdo_acc[tdo_cnt] = tdo_o;
            tdo_cnt++;
            if (tdo_q.size() > 0 && tdo_cnt == tdo_q[0].len) begin
                mon_t = tdo_q.pop_front();
                checkOutput("tdo_stream", tdo_acc, mon_t.val);
                tdo_acc = '0;
                tdo_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] b;
        logic [3:0]   code;
        int           n;
        int           op;

        repeat (2) applyStimulus(1'b1, 1'b0);
        trst_i = 1'b1;
        applyStimulus(1'b0, 1'b0);
        trst_i = 1'b0;
        checkOutput("reset_state", 128'(tapState_o), 128'(ST_TLR));
        checkOutput("reset_tdo", 128'(tdo_o), 128'(0));
        checkOutput("reset_wen", 128'(wEn_o), 128'(0));
        check_model("reset");
        applyStimulus(1'b0, 1'b0);
        checkOutput("rti_state", 128'(tapState_o), 128'(ST_RTI));

        $display("[TB] IDCODE and BYPASS");
        do_expect_tdo(4'b0100, 1'b1, 128'h0, 32, 128'h1000_0A6B);
        b = 128'h93;
        do_expect_tdo(4'b0011, 1'b1, b, 8, bypass_exp(b, 8));

        $display("[TB] single program write and burst");
        do_program(64'h10, 32'h0050_0113, 0);
        check_model("t4");
        for (int i = 0; i < 3; i++) do_burst($urandom);
        check_model("t5");
        checkOutput("burst_last_addr", 128'(loadAddr_o), 128'(64'h13));

        do_program(64'hFFFF_FFFF_FFFF_FFFE, $urandom, 0);
        do_burst($urandom);
        do_burst($urandom);
        checkOutput("wrap_addr", 128'(loadAddr_o), 128'(0));

        $display("[TB] length error and TLR clear");
        do_bad(1'b0, 95);
        check_model("t6");
        go_tlr_then_rti();
        do_expect_tdo(4'b0100, 1'b0, rnd128(), 32, 128'h1000_0A6B);
        do_bad(1'b1, 33);
        check_model("burst_bad");
        go_tlr_then_rti();

        $display("[TB] pause mid-shift, readback, reset on update edge");
        do_program({$urandom, $urandom}, $urandom, 40);
        check_model("pause");
        do_expect_tdo(4'b0010, 1'b1, rnd128(), 96, {32'h0, m_data, m_addr});
        ir_scan(4'b0001);
        dr_scan(rnd128(), 96, 0, 1'b1);
        m_addr = '0;
        m_data = '0;
        m_ptr  = '0;
        m_err  = 1'b0;
        check_model("upd_reset");
        checkOutput("upd_reset_state", 128'(tapState_o), 128'(ST_RTI));
        do_burst($urandom);
        checkOutput("after_reset_ptr", 128'(loadAddr_o), 128'(0));

        $display("[TB] randomized operations");
        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 6);
            case (op)
                0: do_program({$urandom, $urandom}, $urandom, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 95) : 0);
                1: do_burst($urandom);
                2: begin
                    n = $urandom_range(1, 119);
                    if (n >= 96) n++;
                    do_bad(1'b0, n);
                end
                3: begin
                    n = $urandom_range(1, 47);
                    if (n >= 32) n++;
                    do_bad(1'b1, n);
                end
                4: do_expect_tdo(4'b0010, 1'b1, rnd128(), 96, {32'h0, m_data, m_addr});
                5: begin
                    code = 4'($urandom_range(5, 15));
                    if (code == 4'd5) code = 4'd3;
                    n = $urandom_range(1, 20);
                    b = rnd128();
                    do_expect_tdo(code, 1'b1, b, n, bypass_exp(b, n));
                end
                default: go_tlr_then_rti();
            endcase
            check_model("rand");
        end

        repeat (5) applyStimulus(1'b0, 1'b0);
        checkOutput("write_queue_empty", 128'(wr_q.size()), 128'(0));
        checkOutput("tdo_queue_empty", 128'(tdo_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
